// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: state encoding and sizing constants.
package div_pkg;

    localparam int unsigned WIDTH_DIV = 16;
    localparam int unsigned ITER_DIV  = 16;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_FIN  = 3'd4
    } div_state_t;

endpackage

// File: rtl/top_divisor_if.sv
// Start/finish handshake and operand/result bus of the divider.
// ERR exists only when DIV_ERR_EN is defined.
interface top_divisor_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             init;
    logic [WIDTH-1:0] Dividendo;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Cociente;
    logic [WIDTH-1:0] Residuo;
    logic             DONE;
`ifdef DIV_ERR_EN
    logic             ERR;

    modport master (output init, Dividendo, Divisor, input Cociente, Residuo, DONE, ERR);
    modport slave  (input init, Dividendo, Divisor, output Cociente, Residuo, DONE, ERR);
`else
    modport master (output init, Dividendo, Divisor, input Cociente, Residuo, DONE);
    modport slave  (input init, Dividendo, Divisor, output Cociente, Residuo, DONE);
`endif
endinterface

// File: rtl/contador_divisor.sv
// Iteration counter for the divider: loads the iteration count, counts down, flags zero.
module contador_divisor
    import div_pkg::*;
#(
    parameter int unsigned LOAD_VAL = ITER_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             LD,
    input  logic             DEC,
    output logic [CNT_W-1:0] CNT,
    output logic             Z
);

    // Down counter; load has priority over decrement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            CNT <= '0;
        end else if (LD) begin
            CNT <= LOAD_VAL[CNT_W-1:0];
        end else if (DEC) begin
            CNT <= CNT - CNT_W'(1);
        end
    end

    // Zero flag.
    always_comb begin
        Z = (CNT == '0);
    end

endmodule

// File: rtl/top_divisor.sv
// Sequential signed divider, restoring shift-subtract, one quotient bit per clock.
// Quotient truncates toward zero, remainder carries the dividend's sign.
// Optional macro DIV_ERR_EN adds the ERR flag (divide by zero or -2^(W-1) / -1).
module top_divisor
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DIV,
    parameter int unsigned ITER  = WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    top_divisor_if.slave  bus
);

    div_state_t       state;
    logic             sign_q;
    logic             sign_r;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;

    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic             div_zero;
    logic [WIDTH+1:0] r_sh;
    logic [WIDTH+1:0] t_sub;
    logic [WIDTH-1:0] q_neg;
    logic [WIDTH-1:0] r_neg;

    logic [CNT_W-1:0] cnt;
    logic             cnt_z;
    logic             cnt_ld;
    logic             cnt_dec;

`ifdef DIV_ERR_EN
    logic             ovf;
    logic             ovf_q;
`endif

    contador_divisor #(
        .LOAD_VAL (ITER)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .LD    (cnt_ld),
        .DEC   (cnt_dec),
        .CNT   (cnt),
        .Z     (cnt_z)
    );

    // Operand magnitudes, trial subtraction and result negation.
    always_comb begin
        dvd_abs  = bus.Dividendo[WIDTH-1] ? ('0 - bus.Dividendo) : bus.Dividendo;
        dvs_abs  = bus.Divisor[WIDTH-1]   ? ('0 - bus.Divisor)   : bus.Divisor;
        div_zero = (bus.Divisor == '0);
        // R < D always holds, so the shifted remainder never reaches the top bit and
        // t_sub's MSB is a clean borrow.
        r_sh     = {r_reg, q_reg[WIDTH-1]};
        t_sub    = r_sh - {2'b00, d_reg};
        q_neg    = '0 - q_reg;
        r_neg    = '0 - r_reg[WIDTH-1:0];
        cnt_ld   = (state == S_LOAD);
        cnt_dec  = (state == S_ITER) && !cnt_z;
`ifdef DIV_ERR_EN
        ovf      = (bus.Dividendo == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.Divisor == '1);
`endif
    end

    // Control FSM and datapath registers; all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            q_reg        <= '0;
            d_reg        <= '0;
            r_reg        <= '0;
            bus.Cociente <= '0;
            bus.Residuo  <= '0;
            bus.DONE     <= 1'b0;
`ifdef DIV_ERR_EN
            bus.ERR      <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            bus.DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.init) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sign_q <= bus.Dividendo[WIDTH-1] ^ bus.Divisor[WIDTH-1];
                    sign_r <= bus.Dividendo[WIDTH-1];
                    q_reg  <= dvd_abs;
                    d_reg  <= dvs_abs;
                    r_reg  <= '0;
`ifdef DIV_ERR_EN
                    bus.ERR <= div_zero;
                    ovf_q   <= ovf;
`endif
                    if (div_zero) begin
                        bus.Cociente <= '0;
                        bus.Residuo  <= bus.Dividendo;
                        bus.DONE     <= 1'b1;
                        state        <= S_FIN;
                    end else begin
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (t_sub[WIDTH+1]) begin
                        r_reg <= r_sh[WIDTH:0];
                        q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                    end else begin
                        r_reg <= t_sub[WIDTH:0];
                        q_reg <= {q_reg[WIDTH-2:0], 1'b1};
                    end
                    if (cnt == CNT_W'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    bus.Cociente <= sign_q ? q_neg : q_reg;
                    bus.Residuo  <= sign_r ? r_neg : r_reg[WIDTH-1:0];
                    bus.DONE     <= 1'b1;
`ifdef DIV_ERR_EN
                    bus.ERR      <= ovf_q;
`endif
                    state        <= S_FIN;
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top_divisor.sv
// Self-checking bench for top_divisor: vector table, scoreboard queue, handshake and reset sequences.
module tb_top_divisor;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int err;
        int lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    top_divisor_if #(.WIDTH(16)) dif ();

    top_divisor #(
        .WIDTH (16),
        .ITER  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    vec_t vecs[12];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the outputs present now (DONE cycle).
    task automatic compare_result(input string tag, input int lat);
        vec_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: result with empty scoreboard", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, " latency"}, lat, e.lat);
        check({tag, " Cociente"}, $signed(dif.Cociente), e.q);
        check({tag, " Residuo"}, $signed(dif.Residuo), e.r);
`ifdef DIV_ERR_EN
        check({tag, " ERR"}, int'(dif.ERR), e.err);
`endif
    endtask

    // One operation with init pulsed for a single cycle; optionally scramble operands at edge k.
    task automatic run_op(input vec_t v, input string tag, input int scramble_at);
        int lat;
        lat = -1;
        @(negedge clk);
        dif.Dividendo = v.a[15:0];
        dif.Divisor   = v.b[15:0];
        dif.init      = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1 dif.init = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == scramble_at) begin
                dif.Dividendo = 16'h1234;
                dif.Divisor   = 16'hffff;
            end
            if (dif.DONE === 1'b1) begin
                lat = k;
                break;
            end
        end
        compare_result(tag, lat);
        if (lat >= 0) begin
            @(negedge clk);
            check({tag, " DONE one cycle"}, int'(dif.DONE), 0);
        end
    endtask

    initial begin
        vec_t v;
        int   done_at[$];
        int   prev_done;
        int   seen;

        vecs[0]  = '{100, 7, 14, 2, 0, 18};
        vecs[1]  = '{-100, 7, -14, -2, 0, 18};
        vecs[2]  = '{100, -7, -14, 2, 0, 18};
        vecs[3]  = '{-100, -7, 14, -2, 0, 18};
        vecs[4]  = '{7, -100, 0, 7, 0, 18};
        vecs[5]  = '{32767, 1, 32767, 0, 0, 18};
        vecs[6]  = '{-32768, 2, -16384, 0, 0, 18};
        vecs[7]  = '{1234, 0, 0, 1234, 1, 1};
        vecs[8]  = '{-32768, -1, -32768, 0, 1, 18};
        vecs[9]  = '{5, 3, 1, 2, 0, 18};
        vecs[10] = '{-1, 0, 0, -1, 1, 1};
        vecs[11] = '{0, 5, 0, 0, 0, 18};

        dif.init      = 1'b0;
        dif.Dividendo = '0;
        dif.Divisor   = '0;
        reset         = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("reset Cociente", int'(dif.Cociente), 0);
        check("reset Residuo", int'(dif.Residuo), 0);
        check("reset DONE", int'(dif.DONE), 0);
`ifdef DIV_ERR_EN
        check("reset ERR", int'(dif.ERR), 0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i], $sformatf("vec%0d", i), -1);
        end

        // Operands scrambled during ITER must not disturb the result.
        v = '{100, 7, 14, 2, 0, 18};
        run_op(v, "scramble", 5);

        // init held across two operations: one DONE each, one idle cycle between.
        @(negedge clk);
        dif.Dividendo = 16'd100;
        dif.Divisor   = 16'd7;
        dif.init      = 1'b1;
        v = '{100, 7, 14, 2, 0, 18};
        sb.push_back(v);
        prev_done = 0;
        @(posedge clk);
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (dif.DONE === 1'b1) begin
                if (prev_done == 1) begin
                    check("b2b DONE consecutive", 1, 0);
                end
                done_at.push_back(k);
                if (done_at.size() == 1) begin
                    compare_result("b2b op1", k);
                    dif.Dividendo = -16'sd100;
                    dif.Divisor   = 16'd7;
                    v = '{-100, 7, -14, -2, 0, 38};
                    sb.push_back(v);
                end else if (done_at.size() == 2) begin
                    compare_result("b2b op2", k);
                    dif.init = 1'b0;
                end else begin
                    compare_result("b2b extra", k);
                end
            end
            prev_done = (dif.DONE === 1'b1) ? 1 : 0;
        end
        dif.init = 1'b0;
        check("b2b DONE count", done_at.size(), 2);
        if (done_at.size() == 2) begin
            check("b2b spacing", done_at[1] - done_at[0], 20);
        end

        // Asynchronous reset mid-ITER: outputs clear at once, no DONE follows.
        @(negedge clk);
        dif.Dividendo = 16'd1000;
        dif.Divisor   = 16'd3;
        dif.init      = 1'b1;
        @(posedge clk);
        #1 dif.init = 1'b0;
        repeat (6) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midreset Cociente", int'(dif.Cociente), 0);
        check("midreset Residuo", int'(dif.Residuo), 0);
        check("midreset DONE", int'(dif.DONE), 0);
`ifdef DIV_ERR_EN
        check("midreset ERR", int'(dif.ERR), 0);
`endif
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (dif.DONE === 1'b1) seen++;
        end
        reset = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (dif.DONE === 1'b1) seen++;
        end
        check("midreset no DONE", seen, 0);

        v = '{9, 4, 2, 1, 0, 18};
        run_op(v, "after reset", -1);

        check("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/top_divisor.md
Name: top_divisor

Overview:
- Sequential signed 16-bit divider for the calculator datapath; the inverse operation of the shift-add multiplier core.
- Restoring shift-subtract algorithm, one quotient bit per clock, 16 iterations.
- Uses the same init/DONE start-finish handshake as the multiplier core, so the calculator control unit can treat both operators alike.
- Produces quotient and remainder with C/Verilog semantics: quotient truncates toward zero; remainder takes the dividend's sign.

Parameters:
- WIDTH, 16, operand/result width in bits (tested at 16 only).
- ITER, WIDTH, number of shift-subtract iterations; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- init  input  1  start request; sampled only in IDLE.
- Dividendo  input  WIDTH  signed dividend; sampled in LOAD.
- Divisor  input  WIDTH  signed divisor; sampled in LOAD.
- Cociente  output  WIDTH  signed quotient; holds until next LOAD.
- Residuo  output  WIDTH  signed remainder; holds until next LOAD.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  error flag; present only with DIV_ERR_EN.

Behaviour:
- Reset (reset=0, async): state=IDLE; Cociente=0, Residuo=0, DONE=0, ERR=0, counter=0, internal registers 0. Reset mid-operation aborts the operation, and no DONE is produced.
- FSM states: IDLE, LOAD, ITER, FIX, FIN.
  - IDLE: init=1 at an edge -> LOAD. init=0 -> stay.
  - LOAD (1 cycle):
    - latch sign_q = sign(Dividendo) XOR sign(Divisor) and sign_r = sign(Dividendo);
    - Q = |Dividendo| as 16-bit unsigned (|-32768| = 0x8000 is valid);
    - D = |Divisor|, R(17 bits) = 0, counter = ITER.
    - If Divisor == 0: Cociente = 0, Residuo = Dividendo, then -> FIN. Otherwise -> ITER.
  - ITER (16 cycles):
    - {R,Q} shifts left 1;
    - T = R - {0,D};
    - if T >= 0 then R = T and Q[0] = 1, else Q[0] = 0;
    - counter decrements. Leaving with counter reaching 0 -> FIX.
  - FIX (1 cycle):
    - Cociente = sign_q ? -Q : Q, truncated to WIDTH;
    - Residuo = sign_r ? -R[15:0] : R[15:0];
    - -> FIN.
  - FIN (1 cycle): DONE = 1, then -> IDLE.
- Latency, measured from the edge that samples init:
  - normal: DONE high in the cycle after edge +18 (LOAD + 16 ITER + FIX);
  - divide-by-zero: DONE high after edge +1.
- Back-to-back: init held high continuously restarts on the first IDLE cycle after FIN, giving one idle cycle between operations.
- init during LOAD/ITER/FIX/FIN is ignored. Operand changes after LOAD have no effect.
- Overflow: -32768 / -1 gives magnitude 0x8000; negation is not applied since sign_q = 0, so Cociente = 0x8000 (-32768) by wrap, Residuo = 0.
- Outputs change only in LOAD (divide-by-zero case) and FIX. They are stable whenever DONE = 1.
- DONE is never high for two consecutive cycles.

Optional Feature:
- Macro: DIV_ERR_EN.
- Defined:
  - port ERR exists;
  - ERR = 1 in the FIN cycle (coincident with DONE) when Divisor == 0 or (Dividendo == -32768 and Divisor == -1), otherwise 0;
  - ERR registered, reset 0, cleared on the next LOAD.
- Undefined:
  - ERR port and logic absent;
  - numeric results and timing identical.

Decomposition:
- Shared package div_pkg:
  - state encoding constants S_IDLE, S_LOAD, S_ITER, S_FIX, S_FIN (3-bit);
  - WIDTH_DIV = 16;
  - ITER_DIV = 16;
  - counter width CNT_W = 5.
- One natural sub-module, contador_divisor:
  - 5-bit down counter with load (LD loads ITER), decrement (DEC), zero flag (Z);
  - async active-low reset.
- FSM and datapath stay in top_divisor.

Test Plan:
- 100 / 7, init one cycle -> DONE after edge +18; Cociente = 14, Residuo = 2; DONE high exactly one cycle; ERR = 0.
- Sign matrix:
  - -100 / 7 -> -14 r -2;
  - 100 / -7 -> -14 r 2;
  - -100 / -7 -> 14 r -2;
  - 7 / -100 -> 0 r 7;
  - 32767 / 1 -> 32767 r 0;
  - -32768 / 2 -> -16384 r 0.
- 1234 / 0 -> DONE after edge +1; Cociente = 0, Residuo = 1234; ERR = 1 with DIV_ERR_EN.
- -32768 / -1 -> Cociente = -32768, Residuo = 0, ERR = 1; then 5 / 3 -> 1 r 2 with ERR = 0 (flag cleared).
- Handshake:
  - init held high across two operations -> exactly one DONE pulse per operation, one IDLE cycle between them;
  - operands changed during ITER -> results unaffected.
- Reset:
  - reset = 0 asserted asynchronously mid-ITER (between edges) -> all outputs 0 immediately, no DONE;
  - after release, 9 / 4 -> 2 r 1 with normal latency.
